// File: rtl/sync_output_fifo.sv
// Synchronous circular-buffer FIFO with count-decoded status flags and sticky overflow/underflow.
// Define SYNC_OUTPUT_FIFO_FWFT_EN for first-word fall-through reads; otherwise r_data is registered.
module sync_output_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     clear,
  input  logic                     w_enable,
  input  logic [DATA_WIDTH-1:0]    w_data,
  input  logic                     r_enable,
  output logic [DATA_WIDTH-1:0]    r_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic full_s, empty_s;
  logic wr_acc, rd_acc;

  // Status is decoded from the registered count only, never from the request inputs.
  assign full_s       = (count_q == DEPTH_C);
  assign empty_s      = (count_q == '0);
  assign empty        = empty_s;
  assign full         = full_s;
  assign ready        = ~full_s;
  assign almost_full  = (count_q >= AFULL_C);
  assign almost_empty = (count_q <= AEMPTY_C);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write into a full FIFO is admitted when the same edge frees a slot.
  assign wr_acc = w_enable & (~full_s | r_enable) & ~clear;
  assign rd_acc = r_enable & ~empty_s & ~clear;

  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (clear) begin
      count_d = '0;
      wptr_d  = '0;
      rptr_d  = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + 1'b1;
      if (rd_acc) rptr_d = rptr_q + 1'b1;
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (!wr_acc && rd_acc) count_d = count_q - 1'b1;
      if (w_enable && full_s && !r_enable) ovf_d = 1'b1;
      if (r_enable && empty_s)             unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately not reset or cleared; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= w_data;
  end

`ifdef SYNC_OUTPUT_FIFO_FWFT_EN
  // Head entry is visible whenever the FIFO holds data; zero when empty (including reset).
  assign r_data = empty_s ? '0 : mem[rptr_q];
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = mem[rptr_q];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign r_data = rdata_q;
`endif

endmodule

// File: doc/sync_output_fifo.md
SYNC_OUTPUT_FIFO -- requirements
Module: sync_output_fifo

Interface
REQ-001: Parameter DATA_WIDTH, default 8, SHALL set the bit width of w_data and r_data; legal range 1..64.
REQ-002: Parameter DEPTH, default 16, SHALL set the number of storage entries; a power of two, legal range 4..1024.
REQ-003: Parameter AFULL_THRESH, default DEPTH-2, SHALL set the count at or above which almost_full asserts.
REQ-004: Parameter AEMPTY_THRESH, default 2, SHALL set the count at or below which almost_empty asserts.
REQ-005: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006: n_rst  input  1  asynchronous, active-low reset.
REQ-007: clear  input  1  synchronous flush of contents and sticky flags.
REQ-008: w_enable  input  1  write request.
REQ-009: w_data  input  DATA_WIDTH  write data.
REQ-010: r_enable  input  1  read (pop) request.
REQ-011: r_data  output  DATA_WIDTH  read data.
REQ-012: empty  output  1  high when count == 0.
REQ-013: full  output  1  high when count == DEPTH.
REQ-014: almost_full  output  1  high when count >= AFULL_THRESH.
REQ-015: almost_empty  output  1  high when count <= AEMPTY_THRESH.
REQ-016: ready  output  1  equals ~full; upstream may write when high.
REQ-017: count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-018: overflow  output  1  sticky; set by a rejected write.
REQ-019: underflow  output  1  sticky; set by a rejected read.

Function
REQ-020: Storage SHALL be a circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-021: A write SHALL be accepted when w_enable is high and either full is low or r_enable is high in the same cycle; an accepted write stores w_data at the write pointer and increments it.
REQ-022: A read SHALL be accepted when r_enable is high and empty is low; an accepted read increments the read pointer.
REQ-023: count SHALL increment on a write-only accept, decrement on a read-only accept, and hold when both or neither are accepted.
REQ-024: When the FIFO is full and both requests are high, both SHALL be accepted and count SHALL remain DEPTH.
REQ-025: When the FIFO is empty and both requests are high, only the write SHALL be accepted; underflow SHALL be set and count SHALL become 1.
REQ-026: overflow SHALL set on the clock edge where w_enable=1, full=1 and r_enable=0; the write data is discarded.
REQ-027: underflow SHALL set on the clock edge where r_enable=1 and empty=1.
REQ-028: Both sticky flags SHALL stay set until clear or reset.
REQ-029: empty, full, almost_full, almost_empty and ready SHALL be decoded from the registered count only, with no combinational path from w_enable or r_enable.
REQ-030: Without the configured option, r_data SHALL be registered and present the popped entry one cycle after an accepted read; it SHALL hold its value otherwise.
REQ-031: clear SHALL take priority over w_enable and r_enable.
REQ-032: clear SHALL zero count, both pointers and both sticky flags on the next edge; storage contents are not cleared.

Reset
REQ-033: While n_rst=0, the block SHALL immediately force count=0, pointers=0, r_data=0, overflow=0, underflow=0.
REQ-034: During reset the flags SHALL read empty=1, full=0, ready=1, almost_empty=1 and almost_full=0.
REQ-035: Reset asserted mid-transfer SHALL discard all contents; the first write after reset deassertion SHALL land at pointer 0.

Configuration
REQ-036: When macro SYNC_OUTPUT_FIFO_FWFT_EN is defined, the FIFO SHALL use first-word fall-through: r_data shows the head entry whenever empty=0, and r_enable acknowledges (pops) it; the head is valid one cycle after the first write into an empty FIFO.
REQ-037: When SYNC_OUTPUT_FIFO_FWFT_EN is undefined, the FIFO SHALL use the registered read behaviour of REQ-030.

Verification
REQ-038: Defaults: write 0..15 on consecutive cycles -> full=1 after the 16th edge, count=16, almost_full from count=14; then read 16 -> values 0..15 in order, empty=1.
REQ-039: Fill to 16, write 0xAA with r_enable=0 -> overflow=1, 0xAA is never read, count stays 16.
REQ-040: Full FIFO, w_enable=r_enable=1 for 20 cycles -> count stays 16, output order continuous, pointers wrap without loss.
REQ-041: Empty FIFO, r_enable=1 with w_enable=1 and data 0x5C -> underflow=1, count=1; next read returns 0x5C.
REQ-042: Write 5 entries, pulse clear, then write 0x11 -> count=0 and flags cleared after clear; next read returns 0x11.
REQ-043: Assert n_rst=0 mid-stream between clock edges -> outputs reach their reset values without a clock edge; build both with and without SYNC_OUTPUT_FIFO_FWFT_EN and check r_data timing in each.
